// File: rtl/conv_layer_multi.sv
// -----------------------------------------------------------------------------
// conv_layer_multi
//
// Multi-channel 2-D convolution layer. NCU conv units run in parallel, one per
// output column of a group. In each MAC pass every unit accumulates D*S*S
// products for the same output channel k and row r. The NCU results are then
// streamed out one at a time over a valid/ready handshake.
//
// The image and filter buses are read in place, so the source must hold them
// stable while busy is high.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   start      start pulse, sampled only in IDLE
//   img        D*H*W pixels, element 0 at the MSB (d*H*W + y*W + x)
//   fit        K*D*S*S weights, element 0 at the MSB (k*D*S*S + d*S*S + u*S + v)
//   busy       high from start acceptance until done
//   done       one-cycle pulse after the last output is accepted
//   out_valid  result available
//   out_ready  consumer accepts the result
//   out_data   saturated signed result
//   out_ch     output channel of out_data
//   out_row    output row of out_data
//   out_col    output column of out_data
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start
// MAC   | D*S*S cycles; each unit adds one product per cycle
// DRAIN | present NCU results in ascending unit order, then advance (k,r,cg)
// FIN   | done pulse, busy low, back to IDLE
// -----------------------------------------------------------------------------
module conv_layer_multi #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int K          = 4,
    parameter int S          = 3,
    parameter int H          = 8,
    parameter int W          = 8,
    parameter int STRIDE     = 1,
    parameter int NCU        = 2,
    parameter int FRAC       = 0,
    localparam int OH        = (H - S) / STRIDE + 1,
    localparam int OW        = (W - S) / STRIDE + 1,
    localparam int CH_W      = (K  > 1) ? $clog2(K)  : 1,
    localparam int ROW_W     = (OH > 1) ? $clog2(OH) : 1,
    localparam int COL_W     = (OW > 1) ? $clog2(OW) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [D*H*W*DATA_WIDTH-1:0]       img,
    input  logic [K*D*S*S*DATA_WIDTH-1:0]     fit,
    output logic                              busy,
    output logic                              done,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [DATA_WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]                   out_ch,
    output logic [ROW_W-1:0]                  out_row,
    output logic [COL_W-1:0]                  out_col
);

    localparam int N    = D * S * S;
    localparam int NCG  = OW / NCU;
    localparam int NIMG = D * H * W;
    localparam int NFIT = K * N;
    localparam int PW   = 2 * DATA_WIDTH;
    localparam int AW   = PW + $clog2(N);
    localparam int IXW  = (NIMG > 1) ? $clog2(NIMG) : 1;
    localparam int FXW  = (NFIT > 1) ? $clog2(NFIT) : 1;
    localparam int IW   = (N   > 1) ? $clog2(N)   : 1;
    localparam int DW_C = (D   > 1) ? $clog2(D)   : 1;
    localparam int SW   = (S   > 1) ? $clog2(S)   : 1;
    localparam int JW   = (NCU > 1) ? $clog2(NCU) : 1;
    localparam int CGW  = (NCG > 1) ? $clog2(NCG) : 1;

    // Saturation bounds expressed in accumulator width.
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    if (OW % NCU != 0) begin : g_bad_ncu
        $error("conv_layer_multi: NCU must divide the output width");
    end

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, FIN} state_t;

    state_t                 state;
    logic [CH_W-1:0]        k_c;
    logic [ROW_W-1:0]       r_c;
    logic [CGW-1:0]         cg_c;
    logic [JW-1:0]          j_c;
    logic [IW-1:0]          i_c;
    logic [DW_C-1:0]        d_c;
    logic [SW-1:0]          u_c;
    logic [SW-1:0]          v_c;
    logic signed [AW-1:0]   acc [NCU];

    logic signed [DATA_WIDTH-1:0] img_px [NIMG];
    logic signed [DATA_WIDTH-1:0] fit_px [NFIT];
    logic signed [DATA_WIDTH-1:0] wgt;
    logic signed [DATA_WIDTH-1:0] pix     [NCU];
    logic signed [PW-1:0]         prod    [NCU];
    logic signed [AW-1:0]         shifted [NCU];
    logic signed [DATA_WIDTH-1:0] res     [NCU];
    logic                         last_pos;

    // Unpack the flat buses so that element 0 sits at the MSB end.
    for (genvar e = 0; e < NIMG; e++) begin : g_img
        assign img_px[e] = img[(NIMG-1-e)*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar e = 0; e < NFIT; e++) begin : g_fit
        assign fit_px[e] = fit[(NFIT-1-e)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        wgt = fit_px[FXW'(32'(k_c) * N + 32'(i_c))];
        for (int j = 0; j < NCU; j++) begin
            // Unit j covers output column cg*NCU + j; (d,u,v) walk the window.
            pix[j] = img_px[IXW'(32'(d_c) * (H * W)
                                 + (32'(r_c) * STRIDE + 32'(u_c)) * W
                                 + (32'(cg_c) * NCU + 32'(j)) * STRIDE
                                 + 32'(v_c))];
            prod[j]    = PW'(pix[j]) * PW'(wgt);
            shifted[j] = acc[j] >>> FRAC;
            if (shifted[j] > SAT_MAX) begin
                res[j] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end else if (shifted[j] < SAT_MIN) begin
                res[j] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                res[j] = shifted[j][DATA_WIDTH-1:0];
            end
        end
    end

    assign last_pos = (k_c == CH_W'(K - 1)) && (r_c == ROW_W'(OH - 1)) && (cg_c == CGW'(NCG - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_row   <= '0;
            out_col   <= '0;
            k_c       <= '0;
            r_c       <= '0;
            cg_c      <= '0;
            j_c       <= '0;
            i_c       <= '0;
            d_c       <= '0;
            u_c       <= '0;
            v_c       <= '0;
            for (int j = 0; j < NCU; j++) begin
                acc[j] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        k_c   <= '0;
                        r_c   <= '0;
                        cg_c  <= '0;
                        j_c   <= '0;
                        i_c   <= '0;
                        d_c   <= '0;
                        u_c   <= '0;
                        v_c   <= '0;
                        for (int j = 0; j < NCU; j++) begin
                            acc[j] <= '0;
                        end
                        state <= MAC;
                    end
                end

                MAC: begin
                    for (int j = 0; j < NCU; j++) begin
                        acc[j] <= acc[j] + AW'(prod[j]);
                    end
                    if (i_c == IW'(N - 1)) begin
                        i_c   <= '0;
                        d_c   <= '0;
                        u_c   <= '0;
                        v_c   <= '0;
                        j_c   <= '0;
                        state <= DRAIN;
                    end else begin
                        i_c <= i_c + 1'b1;
                        if (v_c == SW'(S - 1)) begin
                            v_c <= '0;
                            if (u_c == SW'(S - 1)) begin
                                u_c <= '0;
                                d_c <= d_c + 1'b1;
                            end else begin
                                u_c <= u_c + 1'b1;
                            end
                        end else begin
                            v_c <= v_c + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (!out_valid) begin
                        // First drain cycle: register unit 0's result.
                        out_valid <= 1'b1;
                        out_data  <= res[0];
                        out_ch    <= k_c;
                        out_row   <= r_c;
                        out_col   <= COL_W'(32'(cg_c) * NCU);
                    end else if (out_ready) begin
                        if (j_c == JW'(NCU - 1)) begin
                            out_valid <= 1'b0;
                            j_c       <= '0;
                            for (int j = 0; j < NCU; j++) begin
                                acc[j] <= '0;
                            end
                            if (last_pos) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= FIN;
                            end else begin
                                if (cg_c == CGW'(NCG - 1)) begin
                                    cg_c <= '0;
                                    if (r_c == ROW_W'(OH - 1)) begin
                                        r_c <= '0;
                                        k_c <= k_c + 1'b1;
                                    end else begin
                                        r_c <= r_c + 1'b1;
                                    end
                                end else begin
                                    cg_c <= cg_c + 1'b1;
                                end
                                state <= MAC;
                            end
                        end else begin
                            // Back-to-back transfers: next unit loads on the accepting edge.
                            j_c      <= j_c + 1'b1;
                            out_data <= res[j_c + JW'(1)];
                            out_col  <= out_col + 1'b1;
                        end
                    end
                end

                FIN: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_multi.sv
// -----------------------------------------------------------------------------
// tb_conv_layer_multi
//
// Two instances of conv_layer_multi:
//   dut16: 16-bit, D=1, K=2, S=3, 7x7 image, stride 2, NCU=3, FRAC=0
//   dut8 :  8-bit, D=2, K=1, S=3, 4x6 image, stride 1, NCU=2, FRAC=1
// Stimulus tasks push the expected outputs into a queue. A monitor per DUT pops
// and compares on every accepted transfer, and checks that stalled outputs
// hold steady.
// -----------------------------------------------------------------------------
module tb_conv_layer_multi;

    localparam int A_DW = 16, A_D = 1, A_K = 2, A_S = 3, A_H = 7, A_W = 7, A_ST = 2, A_NCU = 3, A_FR = 0;
    localparam int A_NIMG = A_D * A_H * A_W;
    localparam int A_NFIT = A_K * A_D * A_S * A_S;
    localparam int A_N    = A_D * A_S * A_S;
    localparam int A_OH   = 3, A_OW = 3;

    localparam int B_DW = 8, B_D = 2, B_K = 1, B_S = 3, B_H = 4, B_W = 6, B_ST = 1, B_NCU = 2, B_FR = 1;
    localparam int B_NIMG = B_D * B_H * B_W;
    localparam int B_NFIT = B_K * B_D * B_S * B_S;
    localparam int B_N    = B_D * B_S * B_S;
    localparam int B_OH   = 2, B_OW = 4;

    typedef struct {
        int data;
        int ch;
        int row;
        int col;
    } exp_t;

    logic clk;

    logic                         rst16, start16, busy16, done16, valid16, ready16;
    logic [A_NIMG*A_DW-1:0]       img16;
    logic [A_NFIT*A_DW-1:0]       fit16;
    logic signed [A_DW-1:0]       data16;
    logic [0:0]                   ch16;
    logic [1:0]                   row16;
    logic [1:0]                   col16;

    logic                         rst8, start8, busy8, done8, valid8, ready8;
    logic [B_NIMG*B_DW-1:0]       img8;
    logic [B_NFIT*B_DW-1:0]       fit8;
    logic signed [B_DW-1:0]       data8;
    logic [0:0]                   ch8;
    logic [0:0]                   row8;
    logic [1:0]                   col8;

    exp_t q16[$];
    exp_t q8[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   done_cnt16 = 0;
    int   done_cnt8  = 0;
    bit   bp16 = 1'b0;

    conv_layer_multi #(
        .DATA_WIDTH(A_DW), .D(A_D), .K(A_K), .S(A_S), .H(A_H), .W(A_W),
        .STRIDE(A_ST), .NCU(A_NCU), .FRAC(A_FR)
    ) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .img(img16), .fit(fit16),
        .busy(busy16), .done(done16), .out_valid(valid16), .out_ready(ready16),
        .out_data(data16), .out_ch(ch16), .out_row(row16), .out_col(col16)
    );

    conv_layer_multi #(
        .DATA_WIDTH(B_DW), .D(B_D), .K(B_K), .S(B_S), .H(B_H), .W(B_W),
        .STRIDE(B_ST), .NCU(B_NCU), .FRAC(B_FR)
    ) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .img(img8), .fit(fit8),
        .busy(busy8), .done(done8), .out_valid(valid8), .out_ready(ready8),
        .out_data(data8), .out_ch(ch8), .out_row(row8), .out_col(col8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_px16(input int e, input int v);
        img16[(A_NIMG-1-e)*A_DW +: A_DW] = A_DW'(v);
    endtask

    task automatic set_w16(input int e, input int v);
        fit16[(A_NFIT-1-e)*A_DW +: A_DW] = A_DW'(v);
    endtask

    task automatic set_px8(input int e, input int v);
        img8[(B_NIMG-1-e)*B_DW +: B_DW] = B_DW'(v);
    endtask

    task automatic set_w8(input int e, input int v);
        fit8[(B_NFIT-1-e)*B_DW +: B_DW] = B_DW'(v);
    endtask

    // Test pattern A on dut16: img[x]=x, filter0 all +1, filter1 all -1.
    // Window sum at (r,c) = 9*(14r+2c) + 7*3*(0+1+2) + 3*(0+1+2) = 126r + 18c + 72.
    task automatic push_a();
        exp_t e;
        for (int k = 0; k < A_K; k++)
            for (int r = 0; r < A_OH; r++)
                for (int c = 0; c < A_OW; c++) begin
                    e.data = (k == 0 ? 1 : -1) * (126 * r + 18 * c + 72);
                    e.ch = k; e.row = r; e.col = c;
                    q16.push_back(e);
                end
    endtask

    // Pattern B on dut16: filter0 = 1 at the centre, filter1 = 2 at (0,0).
    // k0 -> img[(2r+1)*7 + 2c+1] = 14r+2c+8 ; k1 -> 2*img[2r*7 + 2c] = 28r+4c.
    task automatic push_b();
        exp_t e;
        for (int k = 0; k < A_K; k++)
            for (int r = 0; r < A_OH; r++)
                for (int c = 0; c < A_OW; c++) begin
                    e.data = (k == 0) ? (14 * r + 2 * c + 8) : (28 * r + 4 * c);
                    e.ch = k; e.row = r; e.col = c;
                    q16.push_back(e);
                end
    endtask

    task automatic push8(input int v);
        exp_t e;
        for (int r = 0; r < B_OH; r++)
            for (int c = 0; c < B_OW; c++) begin
                e.data = v; e.ch = 0; e.row = r; e.col = c;
                q8.push_back(e);
            end
    endtask

    task automatic fill8(input int px0, input int px1, input int wall);
        for (int e = 0; e < B_H * B_W; e++) begin
            set_px8(e, px0);
            set_px8(B_H * B_W + e, px1);
        end
        for (int e = 0; e < B_NFIT; e++) set_w8(e, wall);
    endtask

    // ---------------- run tasks ----------------
    task automatic run16(input bit rel_rst, input bit poke, input bit chk_grp);
        int cyc;
        int d0;
        d0 = done_cnt16;
        @(posedge clk); #1;
        if (rel_rst) rst16 = 1'b1;
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        check_int("busy16_after_start", int'(busy16), 1);
        cyc = 0;
        while (!valid16 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        check_int("first_valid16_latency", cyc, A_N + 1);
        if (poke) begin
            start16 = 1'b1;
            repeat (4) @(posedge clk);
            #1 start16 = 1'b0;
        end
        if (chk_grp) begin
            cyc = 0;
            while (valid16 && cyc < 200) begin @(posedge clk); #1; cyc++; end
            while (!valid16 && cyc < 200) begin @(posedge clk); #1; cyc++; end
            check_int("group16_period", cyc, A_N + A_NCU + 1);
        end
        cyc = 0;
        while (done_cnt16 == d0 && cyc < 5000) begin @(posedge clk); #1; cyc++; end
        check_int("done16_seen", int'(done_cnt16 != d0), 1);
        repeat (4) @(posedge clk);
        #1;
        check_int("done16_pulses", done_cnt16 - d0, 1);
        check_int("idle16_busy_valid", int'({busy16, valid16}), 0);
        check_int("q16_left", q16.size(), 0);
    endtask

    task automatic run8(input bit chk_grp);
        int cyc;
        int d0;
        d0 = done_cnt8;
        @(posedge clk); #1;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check_int("busy8_after_start", int'(busy8), 1);
        cyc = 0;
        while (!valid8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        check_int("first_valid8_latency", cyc, B_N + 1);
        if (chk_grp) begin
            cyc = 0;
            while (valid8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
            while (!valid8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
            check_int("group8_period", cyc, B_N + B_NCU + 1);
        end
        cyc = 0;
        while (done_cnt8 == d0 && cyc < 5000) begin @(posedge clk); #1; cyc++; end
        check_int("done8_seen", int'(done_cnt8 != d0), 1);
        repeat (4) @(posedge clk);
        #1;
        check_int("done8_pulses", done_cnt8 - d0, 1);
        check_int("idle8_busy_valid", int'({busy8, valid8}), 0);
        check_int("q8_left", q8.size(), 0);
    endtask

    // ---------------- ready driver ----------------
    initial begin
        ready16 = 1'b1;
        ready8  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready16 = bp16 ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // ---------------- monitors ----------------
    initial begin : mon16
        bit   stall;
        int   held;
        exp_t e;
        stall = 1'b0;
        held  = 0;
        forever begin
            @(negedge clk);
            if (done16) begin
                done_cnt16++;
                check_int("busy16_with_done", int'(busy16), 0);
            end
            if (!rst16) begin
                stall = 1'b0;
            end else begin
                if (stall)
                    check_int("hold16", int'({valid16, data16, ch16, row16, col16}), held);
                if (valid16 && ready16) begin
                    stall = 1'b0;
                    if (q16.size() == 0) begin
                        check_int("extra16_output", 1, 0);
                    end else begin
                        e = q16.pop_front();
                        check_int("data16", int'(data16), e.data);
                        check_int("pos16", int'({ch16, row16, col16}), (e.ch << 4) | (e.row << 2) | e.col);
                    end
                end else if (valid16) begin
                    stall = 1'b1;
                    held  = int'({valid16, data16, ch16, row16, col16});
                end else begin
                    stall = 1'b0;
                end
            end
        end
    end

    initial begin : mon8
        exp_t e;
        forever begin
            @(negedge clk);
            if (done8) begin
                done_cnt8++;
                check_int("busy8_with_done", int'(busy8), 0);
            end
            if (rst8 && valid8 && ready8) begin
                if (q8.size() == 0) begin
                    check_int("extra8_output", 1, 0);
                end else begin
                    e = q8.pop_front();
                    check_int("data8", int'(data8), e.data);
                    check_int("pos8", int'({ch8, row8, col8}), (e.ch << 3) | (e.row << 2) | e.col);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int d0;
        rst16 = 1'b0; rst8 = 1'b0;
        start16 = 1'b0; start8 = 1'b0;
        img16 = '0; fit16 = '0; img8 = '0; fit8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset16_state", int'({busy16, done16, valid16, data16, ch16, row16, col16}), 0);
        check_int("reset8_state",  int'({busy8, done8, valid8, data8, ch8, row8, col8}), 0);
        rst8 = 1'b1;
        rst16 = 1'b1;

        // dut8: centre weight 2 on channel 0, all-ones image -> 2 >>> 1 = 1.
        fill8(1, 1, 0);
        set_w8(4, 2);
        push8(1);
        run8(1'b1);

        // dut8: ch0 px 1 * -3, ch1 px 3 * 4 -> 9 >>> 1 = 4.
        fill8(1, 3, 0);
        set_w8(4, -3);
        set_w8(13, 4);
        push8(4);
        run8(1'b0);

        // dut8: -3 >>> 1 = -2 (arithmetic shift rounds toward -inf).
        fill8(1, 3, 0);
        set_w8(4, -3);
        push8(-2);
        run8(1'b0);

        // dut8: saturation both ways.
        fill8(127, 127, 127);
        push8(127);
        run8(1'b0);
        fill8(127, 127, -128);
        push8(-128);
        run8(1'b0);

        // dut16: ramp image, +1 / -1 filters, out_ready held high.
        for (int e = 0; e < A_NIMG; e++) set_px16(e, e);
        for (int e = 0; e < A_NFIT; e++) set_w16(e, (e < A_N) ? 1 : -1);
        push_a();
        run16(1'b0, 1'b0, 1'b1);

        // dut16: same run under 30% out_ready.
        bp16 = 1'b1;
        push_a();
        run16(1'b0, 1'b0, 1'b0);
        bp16 = 1'b0;

        // dut16: single-tap filters check weight/pixel placement.
        for (int e = 0; e < A_NFIT; e++) set_w16(e, 0);
        set_w16(4, 1);
        set_w16(A_N, 2);
        push_b();
        run16(1'b0, 1'b0, 1'b0);

        // dut16: abort during the second group's drain.
        push_b();
        @(posedge clk); #1 start16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        cyc = 0;
        while (!(valid16 && row16 == 2'd1) && cyc < 300) begin @(negedge clk); cyc++; end
        check_int("reached_second_drain", int'(cyc < 300), 1);
        #2 rst16 = 1'b0;
        #1;
        check_int("abort16_outputs", int'({busy16, done16, valid16, data16, ch16, row16, col16}), 0);
        q16.delete();
        d0 = done_cnt16;
        repeat (3) @(posedge clk);
        #1;
        check_int("abort16_no_done", done_cnt16 - d0, 0);

        // Release reset and start on the same cycle; a stray start mid-run is ignored.
        push_b();
        run16(1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
